// File: rtl/regblock_ctrl.sv
// Multi-cycle sequencer: decodes one instruction per handshake, drives the regfile/ALU datapath and a req/ack data port.
// ALU ops take 3 cycles accept-to-accept; load/store add the memory wait. instr_ready is high only in IDLE.
module regblock_ctrl #(
   parameter int         RWIDTH      = 6,
   parameter int         DWIDTH      = 32,
   parameter int         IMM_IN      = 15,
   parameter int         MEM_TIMEOUT = 16,
   parameter logic [3:0] ALU_ADD     = 4'b0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       instr,
   input  logic              instr_valid,
   output logic              instr_ready,
   output logic [RWIDTH-1:0] rs,
   output logic [RWIDTH-1:0] rt,
   output logic [RWIDTH-1:0] rd,
   output logic              we,
   output logic              muxsel1,
   output logic [IMM_IN-1:0] imm_in,
   output logic [3:0]        alu_opsel,
   output logic              wd_sel,
   input  logic [DWIDTH-1:0] alu_result,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DWIDTH-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DWIDTH-1:0] mem_rdata,
   output logic [DWIDTH-1:0] load_data,
   output logic              done,
   output logic              err,
   output logic              halted,
   output logic [31:0]       retire_cnt
);

   localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

   localparam logic [4:0] OP_NOP   = 5'h00;
   localparam logic [4:0] OP_RTYPE = 5'h01;
   localparam logic [4:0] OP_LOAD  = 5'h04;
   localparam logic [4:0] OP_STORE = 5'h05;
   localparam logic [4:0] OP_HALT  = 5'h1F;

   typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

   state_t        state;
   logic [4:0]    op_q;
   logic [WW-1:0] wait_cnt;
   logic [4:0]    op_in;
   logic          is_alu_q;
   logic          is_mem_q;

   assign op_in    = instr[31:27];
   assign is_alu_q = (op_q == OP_RTYPE) || (op_q[4:3] == 2'b10);
   assign is_mem_q = (op_q == OP_LOAD) || (op_q == OP_STORE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         op_q        <= '0;
         wait_cnt    <= '0;
         instr_ready <= 1'b0;
         rs          <= '0;
         rt          <= '0;
         rd          <= '0;
         we          <= 1'b0;
         muxsel1     <= 1'b0;
         imm_in      <= '0;
         alu_opsel   <= '0;
         wd_sel      <= 1'b0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         load_data   <= '0;
         done        <= 1'b0;
         err         <= 1'b0;
         halted      <= 1'b0;
         retire_cnt  <= '0;
      end else begin
         done   <= 1'b0;
         we     <= 1'b0;
         wd_sel <= 1'b0;
         case (state)
            S_IDLE: begin
               instr_ready <= 1'b1;
               if (instr_ready && instr_valid) begin
                  instr_ready <= 1'b0;
                  op_q        <= op_in;
                  state       <= S_DECODE;
                  rs          <= RWIDTH'(instr[26:21]);
                  rt          <= RWIDTH'(instr[20:15]);
                  imm_in      <= IMM_IN'(instr[14:0]);
                  // Control fields are settled at accept so they are stable through DECODE and EXEC.
                  if (op_in == OP_RTYPE) begin
                     rd        <= RWIDTH'(instr[14:9]);
                     alu_opsel <= instr[3:0];
                     muxsel1   <= 1'b0;
                  end else if (op_in[4:3] == 2'b10) begin
                     rd        <= RWIDTH'(instr[20:15]);
                     alu_opsel <= {1'b0, op_in[2:0]};
                     muxsel1   <= 1'b1;
                  end else if (op_in == OP_LOAD || op_in == OP_STORE) begin
                     rd        <= RWIDTH'(instr[20:15]);
                     alu_opsel <= ALU_ADD;
                     muxsel1   <= 1'b1;
                  end else begin
                     rd        <= RWIDTH'(instr[20:15]);
                     alu_opsel <= instr[3:0];
                     muxsel1   <= 1'b0;
                  end
               end
            end
            S_DECODE: begin
               if (op_q == OP_NOP) begin
                  done        <= 1'b1;
                  retire_cnt  <= retire_cnt + 32'd1;
                  instr_ready <= 1'b1;
                  state       <= S_IDLE;
               end else if (op_q == OP_HALT) begin
                  done   <= 1'b1;
                  halted <= 1'b1;
                  state  <= S_HALT;
               end else if (is_alu_q) begin
                  we         <= 1'b1;
                  done       <= 1'b1;
                  retire_cnt <= retire_cnt + 32'd1;
                  state      <= S_EXEC;
               end else if (is_mem_q) begin
                  state <= S_EXEC;
               end else begin
                  err         <= 1'b1;
                  done        <= 1'b1;
                  instr_ready <= 1'b1;
                  state       <= S_IDLE;
               end
            end
            S_EXEC: begin
               if (is_mem_q) begin
                  mem_addr <= alu_result;
                  mem_req  <= 1'b1;
                  mem_we   <= (op_q == OP_STORE);
                  wait_cnt <= '0;
                  state    <= S_MEM;
               end else begin
                  instr_ready <= 1'b1;
                  state       <= S_IDLE;
               end
            end
            S_MEM: begin
               // An ack arriving on the last allowed wait cycle still completes the access.
               if (mem_ack) begin
                  mem_req    <= 1'b0;
                  mem_we     <= 1'b0;
                  done       <= 1'b1;
                  retire_cnt <= retire_cnt + 32'd1;
                  if (op_q == OP_LOAD) begin
                     load_data <= mem_rdata;
                     we        <= 1'b1;
                     wd_sel    <= 1'b1;
                     state     <= S_WB;
                  end else begin
                     instr_ready <= 1'b1;
                     state       <= S_IDLE;
                  end
               end else if (wait_cnt == WW'(MEM_TIMEOUT - 1)) begin
                  mem_req     <= 1'b0;
                  mem_we      <= 1'b0;
                  err         <= 1'b1;
                  done        <= 1'b1;
                  instr_ready <= 1'b1;
                  state       <= S_IDLE;
               end else begin
                  wait_cnt <= wait_cnt + WW'(1);
               end
            end
            S_WB: begin
               instr_ready <= 1'b1;
               state       <= S_IDLE;
            end
            default: begin
               instr_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule
